// File: rtl/complex_nr_pkg.sv
// Shared types and constants for the complex_nr_acc product accumulator.
package complex_nr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Largest positive value of a signed w-bit accumulator part.
    function automatic longint acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/complex_nr_acc_add.sv
// One signed accumulator-width adder; saturates when COMPLEX_NR_ACC_SAT_EN is defined,
// otherwise wraps modulo 2^ACC_WIDTH.
module complex_nr_acc_add
    import complex_nr_pkg::*;
#(
    parameter int ACC_WIDTH = 20
) (
    input  logic signed [ACC_WIDTH-1:0] i_a,
    input  logic signed [ACC_WIDTH-1:0] i_b,
    output logic signed [ACC_WIDTH-1:0] o_sum
);

`ifdef COMPLEX_NR_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

    logic [ACC_WIDTH:0] w_full;

    assign w_full = {i_a[ACC_WIDTH-1], i_a} + {i_b[ACC_WIDTH-1], i_b};

    // Overflow shows up as disagreement between the guard bit and the sign bit.
    always_comb begin
        o_sum = w_full[ACC_WIDTH-1:0];
        if (w_full[ACC_WIDTH] != w_full[ACC_WIDTH-1]) begin
            if (w_full[ACC_WIDTH] == 1'b0) begin
                o_sum = SAT_MAX;
            end else begin
                o_sum = SAT_MIN;
            end
        end else begin
            o_sum = w_full[ACC_WIDTH-1:0];
        end
    end
`else
    assign o_sum = i_a + i_b;
`endif

endmodule

// File: rtl/complex_nr_acc.sv
// Complex product accumulator: sums acc_len consecutive products into one complex sum.
// Optional saturating addition is enabled with the COMPLEX_NR_ACC_SAT_EN macro.
module complex_nr_acc
    import complex_nr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 2 * DATA_WIDTH + 1,
    parameter int LEN_WIDTH  = 4,
    parameter int ACC_WIDTH  = RES_WIDTH + LEN_WIDTH
) (
    input  logic                        clk,
    input  logic                        sw_rst,
    input  logic                        res_val,
    output logic                        res_ready,
    input  logic signed [RES_WIDTH-1:0] res_re,
    input  logic signed [RES_WIDTH-1:0] res_im,
    input  logic        [LEN_WIDTH-1:0] acc_len,
    output logic                        sum_val,
    input  logic                        sum_ready,
    output logic signed [ACC_WIDTH-1:0] sum_re,
    output logic signed [ACC_WIDTH-1:0] sum_im,
    output logic                        busy
);

    state_t                      r_state;
    logic signed [ACC_WIDTH-1:0] r_acc_re;
    logic signed [ACC_WIDTH-1:0] r_acc_im;
    logic        [LEN_WIDTH-1:0] r_cnt;
    logic        [LEN_WIDTH-1:0] r_len;
    logic                        r_res_ready;
    logic                        r_sum_val;
    logic                        r_busy;

    state_t                      w_state_nxt;
    logic signed [ACC_WIDTH-1:0] w_acc_re_nxt;
    logic signed [ACC_WIDTH-1:0] w_acc_im_nxt;
    logic        [LEN_WIDTH-1:0] w_cnt_nxt;
    logic        [LEN_WIDTH-1:0] w_len_nxt;
    logic        [LEN_WIDTH-1:0] w_len_first;
    logic signed [ACC_WIDTH-1:0] w_prod_re;
    logic signed [ACC_WIDTH-1:0] w_prod_im;
    logic signed [ACC_WIDTH-1:0] w_add_re;
    logic signed [ACC_WIDTH-1:0] w_add_im;
    logic                        w_accept;

    assign w_accept    = res_val && r_res_ready;
    assign w_prod_re   = ACC_WIDTH'(res_re);
    assign w_prod_im   = ACC_WIDTH'(res_im);
    assign w_len_first = (acc_len == '0) ? LEN_WIDTH'(1'b1) : acc_len;

    complex_nr_acc_add #(.ACC_WIDTH(ACC_WIDTH)) u_add_re (
        .i_a   (r_acc_re),
        .i_b   (w_prod_re),
        .o_sum (w_add_re)
    );

    complex_nr_acc_add #(.ACC_WIDTH(ACC_WIDTH)) u_add_im (
        .i_a   (r_acc_im),
        .i_b   (w_prod_im),
        .o_sum (w_add_im)
    );

    // Next-state and datapath selection for the burst FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_re_nxt = r_acc_re;
        w_acc_im_nxt = r_acc_im;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_len;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_acc_re_nxt = w_prod_re;
                    w_acc_im_nxt = w_prod_im;
                    w_cnt_nxt    = LEN_WIDTH'(1'b1);
                    w_len_nxt    = w_len_first;
                    if (w_len_first == LEN_WIDTH'(1'b1)) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_ACC;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (w_accept) begin
                    w_acc_re_nxt = w_add_re;
                    w_acc_im_nxt = w_add_im;
                    w_cnt_nxt    = r_cnt + LEN_WIDTH'(1'b1);
                    if ((r_cnt + LEN_WIDTH'(1'b1)) == r_len) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_ACC;
                    end
                end else begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (sum_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered handshake outputs; handshakes are decoded from the next state.
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_state     <= ST_IDLE;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_res_ready <= 1'b1;
            r_sum_val   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc_re    <= w_acc_re_nxt;
            r_acc_im    <= w_acc_im_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_res_ready <= (w_state_nxt != ST_HOLD);
            r_sum_val   <= (w_state_nxt == ST_HOLD);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign res_ready = r_res_ready;
    assign sum_val   = r_sum_val;
    assign busy      = r_busy;
    assign sum_re    = r_acc_re;
    assign sum_im    = r_acc_im;

endmodule

// File: tb/tb_complex_nr_acc.sv
// Self-checking bench for complex_nr_acc: vector table, corner sequences, random bursts.
module tb_complex_nr_acc;

    localparam int RW  = 17;
    localparam int LW  = 4;
    localparam int AW  = 20;
    localparam int AW2 = 18;
`ifdef COMPLEX_NR_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 sw_rst;
    logic                 res_val, res_ready, sum_val, sum_ready, busy;
    logic signed [RW-1:0] res_re, res_im;
    logic        [LW-1:0] acc_len;
    logic signed [AW-1:0] sum_re, sum_im;

    logic                  v2, rdy2, sv2, sr2, busy2;
    logic signed [RW-1:0]  re2, im2;
    logic        [LW-1:0]  len2;
    logic signed [AW2-1:0] s_re2, s_im2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int     len;
        int     n;
        longint re [4];
        longint im [4];
        longint exp_re;
        longint exp_im;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    complex_nr_acc #(.DATA_WIDTH(8), .RES_WIDTH(RW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .sw_rst(sw_rst), .res_val(res_val), .res_ready(res_ready),
        .res_re(res_re), .res_im(res_im), .acc_len(acc_len), .sum_val(sum_val),
        .sum_ready(sum_ready), .sum_re(sum_re), .sum_im(sum_im), .busy(busy)
    );

    complex_nr_acc #(.DATA_WIDTH(8), .RES_WIDTH(RW), .LEN_WIDTH(LW), .ACC_WIDTH(AW2)) dut_ovf (
        .clk(clk), .sw_rst(sw_rst), .res_val(v2), .res_ready(rdy2),
        .res_re(re2), .res_im(im2), .acc_len(len2), .sum_val(sv2),
        .sum_ready(sr2), .sum_re(s_re2), .sum_im(s_im2), .busy(busy2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer sum, clamped per step when saturating, wrapped at the end otherwise.
    function automatic longint model(input longint p [16], input int n, input int w, input bit sat);
        longint s  = 0;
        longint m  = 64'sd1 <<< w;
        longint hi = (m / 2) - 1;
        longint lo = -(m / 2);
        for (int k = 0; k < n; k++) begin
            s = s + p[k];
            if (sat && s > hi) s = hi;
            if (sat && s < lo) s = lo;
        end
        if (!sat) begin
            s = s % m;
            if (s > hi) s = s - m;
            if (s < lo) s = s + m;
        end
        return s;
    endfunction

    task automatic send(input longint re, input longint im);
        int guard = 0;
        res_re  = RW'(re);
        res_im  = RW'(im);
        res_val = 1'b1;
        while (!res_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("res_ready_on_send", longint'(res_ready), longint'(1));
        tick();
        res_val = 1'b0;
    endtask

    task automatic collect(input string name, input longint exp_re, input longint exp_im,
                           input int hold);
        check({name, "_sum_val"}, longint'(sum_val), longint'(1));
        check({name, "_re"}, longint'(sum_re), exp_re);
        check({name, "_im"}, longint'(sum_im), exp_im);
        check({name, "_ready_low"}, longint'(res_ready), longint'(0));
        for (int h = 0; h < hold; h++) begin
            sum_ready = 1'b0;
            tick();
            check({name, "_hold_val"}, longint'(sum_val), longint'(1));
            check({name, "_hold_re"}, longint'(sum_re), exp_re);
            check({name, "_hold_im"}, longint'(sum_im), exp_im);
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        check({name, "_done_val"}, longint'(sum_val), longint'(0));
        check({name, "_done_busy"}, longint'(busy), longint'(0));
        check({name, "_done_ready"}, longint'(res_ready), longint'(1));
    endtask

    initial begin
        longint pr [16];
        longint pi [16];
        logic signed [RW-1:0] tmp;
        int len, n;

        sw_rst = 1'b1; res_val = 1'b0; sum_ready = 1'b0; res_re = '0; res_im = '0; acc_len = '0;
        v2 = 1'b0; sr2 = 1'b0; re2 = '0; im2 = '0; len2 = '0;
        tick();
        tick();
        sw_rst = 1'b0;
        check("rst_res_ready", longint'(res_ready), longint'(1));
        check("rst_sum_val", longint'(sum_val), longint'(0));
        check("rst_busy", longint'(busy), longint'(0));
        check("rst_sum_re", longint'(sum_re), longint'(0));
        check("rst_sum_im", longint'(sum_im), longint'(0));

        tbl[0].len = 1; tbl[0].n = 1;
        tbl[0].re = '{2, 0, 0, 0};    tbl[0].im = '{16, 0, 0, 0};
        tbl[0].exp_re = 2;            tbl[0].exp_im = 16;
        tbl[1].len = 3; tbl[1].n = 3;
        tbl[1].re = '{2, -1, 10, 0};  tbl[1].im = '{16, 5, -20, 0};
        tbl[1].exp_re = 11;           tbl[1].exp_im = 1;
        tbl[2].len = 0; tbl[2].n = 1;
        tbl[2].re = '{5, 0, 0, 0};    tbl[2].im = '{5, 0, 0, 0};
        tbl[2].exp_re = 5;            tbl[2].exp_im = 5;
        tbl[3].len = 2; tbl[3].n = 2;
        tbl[3].re = '{-65536, -65536, 0, 0}; tbl[3].im = '{65535, 65535, 0, 0};
        tbl[3].exp_re = -131072;      tbl[3].exp_im = 131070;
        tbl[4].len = 4; tbl[4].n = 4;
        tbl[4].re = '{1, 2, 3, 4};    tbl[4].im = '{-1, -2, -3, -4};
        tbl[4].exp_re = 10;           tbl[4].exp_im = -10;

        for (int v = 0; v < 5; v++) begin
            acc_len = LW'(tbl[v].len);
            for (int k = 0; k < tbl[v].n; k++) begin
                send(tbl[v].re[k], tbl[v].im[k]);
                if (k == 0) acc_len = LW'($urandom);
                if (k < tbl[v].n - 1) begin
                    check("vec_busy_mid", longint'(busy), longint'(1));
                    check("vec_val_mid", longint'(sum_val), longint'(0));
                end
            end
            collect($sformatf("vec%0d", v), tbl[v].exp_re, tbl[v].exp_im, v);
        end

        // Backpressure: a product waits on res_val while the sum is held.
        acc_len = 4'd2;
        send(100, -100);
        send(23, 7);
        acc_len = 4'd1;
        res_re = 17'sd9; res_im = -17'sd4; res_val = 1'b1;
        for (int h = 0; h < 5; h++) begin
            check("bp_ready_low", longint'(res_ready), longint'(0));
            check("bp_val", longint'(sum_val), longint'(1));
            check("bp_re", longint'(sum_re), longint'(123));
            check("bp_im", longint'(sum_im), longint'(-93));
            tick();
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        check("bp_after_hs_val", longint'(sum_val), longint'(0));
        check("bp_after_hs_ready", longint'(res_ready), longint'(1));
        tick();
        res_val = 1'b0;
        collect("bp_next", 9, -4, 0);

        // Reset mid-burst, with a concurrent valid product that must be ignored.
        acc_len = 4'd4;
        send(50, 60);
        send(70, 80);
        sw_rst = 1'b1;
        res_val = 1'b1;
        tick();
        sw_rst = 1'b0;
        res_val = 1'b0;
        check("rst_mid_busy", longint'(busy), longint'(0));
        check("rst_mid_val", longint'(sum_val), longint'(0));
        check("rst_mid_ready", longint'(res_ready), longint'(1));
        tick();
        check("rst_mid_idle_val", longint'(sum_val), longint'(0));
        acc_len = 4'd1;
        send(7, -3);
        collect("rst_next", 7, -3, 1);

        // Overflow on the narrow-accumulator instance.
        len2 = 4'd4;
        re2 = 17'sd65535;
        im2 = -17'sd65536;
        v2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_ready", longint'(rdy2), longint'(1));
            tick();
        end
        v2 = 1'b0;
        check("ovf_val", longint'(sv2), longint'(1));
        check("ovf_re", longint'(s_re2), SAT ? longint'(131071) : longint'(-4));
        check("ovf_im", longint'(s_im2), SAT ? longint'(-131072) : longint'(0));
        sr2 = 1'b1;
        tick();
        sr2 = 1'b0;
        check("ovf_done", longint'(sv2), longint'(0));

        // Random bursts with gaps, mid-burst acc_len changes and backpressure.
        for (int b = 0; b < 40; b++) begin
            len = int'($urandom_range(0, 15));
            n = (len == 0) ? 1 : len;
            acc_len = LW'(len);
            for (int k = 0; k < n; k++) begin
                tmp = RW'($urandom);
                pr[k] = longint'(tmp);
                tmp = RW'($urandom);
                pi[k] = longint'(tmp);
                if (k > 0) begin
                    repeat ($urandom_range(0, 2)) tick();
                end
                send(pr[k], pi[k]);
                if (k == 0) acc_len = LW'($urandom);
            end
            collect($sformatf("rnd%0d", b), model(pr, n, AW, SAT), model(pi, n, AW, SAT),
                    int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
